// File: rtl/hs_pipe_buffer_pkg.sv
// hs_pkg: occupancy encoding and stall counter width shared by the pipe buffer files.
package hs_pkg;
  localparam int HS_STALL_CNT_W = 16;
  typedef enum logic [1:0] {HS_EMPTY, HS_ONE, HS_TWO} hs_occ_e;
endpackage

// File: rtl/hs_pipe_buffer_if.sv
// hs_pipe_buffer_if: upstream and downstream valid/ready handshake of the pipe buffer.
interface hs_pipe_buffer_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic valid_i;
  logic ready_o;
  logic valid_o;
  logic ready_i;
  modport slave(input in, valid_i, ready_i, output ready_o, out, valid_o);
  modport master(output in, valid_i, ready_i, input ready_o, out, valid_o);
endinterface

// File: rtl/hs_pipe_buffer_slot.sv
// hs_pipe_slot: payload register with load enable, async active-low reset to 0.
module hs_pipe_slot #(parameter int WIDTH = 1) (
  input  logic             clk_core,
  input  logic             rst_core_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/hs_pipe_buffer.sv
// hs_pipe_buffer: two-entry registered valid/ready buffer; all outputs come from flops.
// Optional stall counter enabled by defining HS_PIPE_STALL_CNT_EN.
module hs_pipe_buffer
  import hs_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                      clk_core,
  input  logic                      rst_core_n,
  input  logic                      flush,
  hs_pipe_buffer_if.slave           bus,
  output logic [HS_STALL_CNT_W-1:0] stall_cnt
);
  hs_occ_e          state;
  logic             push, pop, head_load, tail_load;
  logic [WIDTH-1:0] head_d, tail_q;
  assign push = bus.valid_i & bus.ready_o;
  assign pop  = bus.valid_o & bus.ready_i;
  // flush freezes the data registers; only the occupancy is discarded
  always_comb begin
    head_load = !flush && ((state == HS_EMPTY && push) ||
                           (state == HS_ONE && push && pop) ||
                           (state == HS_TWO && pop));
    tail_load = !flush && state == HS_ONE && push && !pop;
    head_d    = state == HS_TWO ? tail_q : bus.in;
  end
  hs_pipe_slot #(.WIDTH(WIDTH)) u_head (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .load      (head_load),
    .d         (head_d),
    .q         (bus.out)
  );
  hs_pipe_slot #(.WIDTH(WIDTH)) u_tail (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .load      (tail_load),
    .d         (bus.in),
    .q         (tail_q)
  );
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      state       <= HS_EMPTY;
      bus.ready_o <= 1'b1;
      bus.valid_o <= 1'b0;
    end else if (flush) begin
      state       <= HS_EMPTY;
      bus.ready_o <= 1'b1;
      bus.valid_o <= 1'b0;
    end else begin
      case (state)
        HS_EMPTY:
          if (push) begin
            state       <= HS_ONE;
            bus.valid_o <= 1'b1;
          end
        HS_ONE:
          if (push && !pop) begin
            state       <= HS_TWO;
            bus.ready_o <= 1'b0;
          end else if (pop && !push) begin
            state       <= HS_EMPTY;
            bus.valid_o <= 1'b0;
          end
        HS_TWO:
          if (pop) begin
            state       <= HS_ONE;
            bus.ready_o <= 1'b1;
          end
        default: begin
          state       <= HS_EMPTY;
          bus.ready_o <= 1'b1;
          bus.valid_o <= 1'b0;
        end
      endcase
    end
`ifdef HS_PIPE_STALL_CNT_EN
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) stall_cnt <= '0;
    else if (flush) stall_cnt <= '0;
    else if (bus.valid_o && !bus.ready_i && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hs_pipe_buffer.sv
// tb_hs_pipe_buffer: queue-model scoreboard for hs_pipe_buffer with directed and random traffic.
module tb_hs_pipe_buffer;
  import hs_pkg::*;
  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  logic flush = 1'b0;
  logic [HS_STALL_CNT_W-1:0] stall_cnt;
  hs_pipe_buffer_if #(.WIDTH(8)) bus ();
  hs_pipe_buffer #(.WIDTH(8)) dut (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );
  always #5 clk_core = ~clk_core;
  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [7:0] q[$];
  int unsigned stall_m = 0;
  logic pushed = 1'b0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: a bounded FIFO of at most two beats, evaluated mid-cycle
  always @(negedge clk_core) begin
    logic do_push, do_pop;
    if (!rst_core_n) begin
      q.delete();
      stall_m = 0;
      pushed = 1'b0;
      chk("rst_ready_o", bus.ready_o, 1);
      chk("rst_valid_o", bus.valid_o, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
    end else begin
      chk("valid_o", bus.valid_o, q.size() > 0);
      chk("ready_o", bus.ready_o, q.size() < 2);
      if (q.size() > 0) chk("out", bus.out, q[0]);
`ifdef HS_PIPE_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stall_m);
`else
      chk("stall_cnt", stall_cnt, 0);
`endif
      do_push = bus.valid_i && q.size() < 2;
      do_pop = q.size() > 0 && bus.ready_i;
      pushed = do_push && !flush;
      if (flush) begin
        q.delete();
        stall_m = 0;
      end else begin
        if (q.size() > 0 && !bus.ready_i && stall_m < 65535) stall_m++;
        if (do_pop) begin
          void'(q.pop_front());
          popped++;
        end
        if (do_push) q.push_back(bus.in);
      end
    end
  end
  task automatic drive(logic v, logic [7:0] d, logic r, logic f);
    logic [7:0] o;
    logic vo, ro;
    @(posedge clk_core);
    #1;
    o = bus.out;
    vo = bus.valid_o;
    ro = bus.ready_o;
    bus.valid_i = v;
    bus.in = d;
    bus.ready_i = r;
    flush = f;
    #1;
    chk("no_comb_path", {vo, ro, o}, {bus.valid_o, bus.ready_o, bus.out});
  endtask
  initial begin
    logic v;
    logic [7:0] d;
    int cyc;
    bus.valid_i = 1'b0;
    bus.in = '0;
    bus.ready_i = 1'b0;
    repeat (2) @(posedge clk_core);
    #3 rst_core_n = 1'b1;
    drive(0, 8'h00, 1, 0);
    drive(1, 8'h11, 1, 0);
    drive(1, 8'h22, 1, 0);
    drive(1, 8'h33, 1, 0);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    drive(1, 8'hA5, 0, 0);
    drive(1, 8'h5A, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("two_ready_o", bus.ready_o, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    drive(1, 8'h01, 0, 0);
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h03, 0, 1);
    drive(0, 8'h00, 1, 0);
    chk("flush_valid_o", bus.valid_o, 0);
    chk("flush_ready_o", bus.ready_o, 1);
    drive(0, 8'h00, 1, 0);
`ifdef HS_PIPE_STALL_CNT_EN
    drive(1, 8'h77, 0, 0);
    repeat (70000) drive(0, 8'h00, 0, 0);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 1, 0);
    chk("stall_flush", stall_cnt, 0);
`endif
    drive(1, 8'h44, 0, 0);
    drive(1, 8'h55, 0, 0);
    @(posedge clk_core);
    #3;
    bus.valid_i = 1'b0;
    flush = 1'b0;
    rst_core_n = 1'b0;
    #1;
    chk("async_rst_valid_o", bus.valid_o, 0);
    chk("async_rst_ready_o", bus.ready_o, 1);
    chk("async_rst_out", bus.out, 0);
    @(posedge clk_core);
    #3 rst_core_n = 1'b1;
    drive(1, 8'h66, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("post_rst_out", bus.out, 8'h66);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    popped = 0;
    v = 1'b0;
    d = '0;
    cyc = 0;
    while (popped < 10000 && cyc < 60000) begin
      if (!v || pushed) begin
        v = $urandom_range(0, 3) != 0;
        d = 8'($urandom);
      end
      drive(v, d, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
      cyc++;
    end
    chk("random_beats_done", popped >= 10000, 1);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
